// File: rtl/game_flow_controller_if.sv
// Handshake/bus bundle between the beam/control side and game_flow_controller.
// master drives the frame/button/doodle inputs; slave is the sequencer.
interface game_flow_controller_if #(
  parameter int SCORE_W = 16
);
  logic               switch_frame;
  logic               button_left;
  logic               button_right;
  logic [9:0]         doodle_y;
  logic               doodle_falling;
  logic [1:0]         state;
  logic               frame_tick;
  logic               doodle_enable;
  logic               world_rst;
  logic [4:0]         scroll_step;
  logic [15:0]        scroll_total;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] best_score;

  modport master (
    output switch_frame, button_left, button_right,
    output doodle_y, doodle_falling,
    input  state, frame_tick, doodle_enable, world_rst,
    input  scroll_step, scroll_total, score, best_score
  );

  modport slave (
    input  switch_frame, button_left, button_right,
    input  doodle_y, doodle_falling,
    output state, frame_tick, doodle_enable, world_rst,
    output scroll_step, scroll_total, score, best_score
  );
endinterface

// File: rtl/game_flow_controller.sv
// Per-frame game sequencer: frame edge detect, IDLE/RESTART/PLAY/OVER FSM,
// scroll step, scroll offset, saturating score and best score.
module game_flow_controller #(
  parameter int SCROLL_LINE    = 300,
  parameter int DEATH_LINE     = 710,
  parameter int MAX_STEP       = 16,
  parameter int RESTART_CYCLES = 4,
  parameter int SCORE_W        = 16
) (
  input logic             clk,
  input logic             rst,
  game_flow_controller_if.slave gf_io
);
  localparam int CW = $clog2(RESTART_CYCLES + 1);
  localparam logic [9:0] SCROLL_Y = 10'(SCROLL_LINE);
  localparam logic [9:0] DEATH_Y  = 10'(DEATH_LINE);
  localparam logic [9:0] MAX_Y    = 10'(MAX_STEP);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESTART = 2'd1,
    S_PLAY    = 2'd2,
    S_OVER    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               sf_q;
  logic               btn_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tick_q;
  logic               en_q;
  logic               wrst_q;
  logic [4:0]         step_q, step_d;
  logic [15:0]        tot_q, tot_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] best_q, best_d;

  logic               btn;
  logic               press;
  logic               frame_e;
  logic [9:0]         gap;
  logic [4:0]         step_amt;
  logic [SCORE_W:0]   score_sum;

  assign btn     = gf_io.button_left | gf_io.button_right;
  assign press   = btn & ~btn_q;
  assign frame_e = sf_q & ~gf_io.switch_frame;
  assign gap     = SCROLL_Y - gf_io.doodle_y;
  assign step_amt = (gap > MAX_Y) ? MAX_Y[4:0] : gap[4:0];
  assign score_sum = {1'b0, score_q}
                   + {{(SCORE_W-4){1'b0}}, step_amt};

  // Next state, restart counter, scroll and score bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 5'd0;
    tot_d   = tot_q;
    score_d = score_q;
    best_d  = best_q;
    unique case (state_q)
      S_IDLE: begin
        if (press) state_d = S_RESTART;
      end
      S_RESTART: begin
        if (cnt_q == CW'(1)) state_d = S_PLAY;
        else cnt_d = cnt_q - CW'(1);
      end
      S_PLAY: begin
        if (frame_e) begin
          if (gf_io.doodle_y >= DEATH_Y) begin
            state_d = S_OVER;
          end else if (!gf_io.doodle_falling &&
                       gf_io.doodle_y < SCROLL_Y) begin
            step_d  = step_amt;
            tot_d   = tot_q + {11'd0, step_amt};
            score_d = score_sum[SCORE_W] ? '1
                    : score_sum[SCORE_W-1:0];
          end
        end
      end
      S_OVER: begin
        if (press) state_d = S_RESTART;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_RESTART && state_q != S_RESTART) begin
      cnt_d   = CW'(RESTART_CYCLES);
      tot_d   = 16'd0;
      score_d = '0;
    end
    if (state_d == S_OVER && state_q != S_OVER &&
        score_q > best_q) begin
      best_d = score_q;
    end
  end

  // State and registered outputs; reset clears everything incl. best
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sf_q    <= 1'b1;
      btn_q   <= 1'b1;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      en_q    <= 1'b0;
      wrst_q  <= 1'b0;
      step_q  <= 5'd0;
      tot_q   <= 16'd0;
      score_q <= '0;
      best_q  <= '0;
    end else begin
      state_q <= state_d;
      sf_q    <= gf_io.switch_frame;
      btn_q   <= btn;
      cnt_q   <= cnt_d;
      tick_q  <= frame_e;
      en_q    <= (state_d == S_PLAY);
      wrst_q  <= (state_d == S_RESTART);
      step_q  <= step_d;
      tot_q   <= tot_d;
      score_q <= score_d;
      best_q  <= best_d;
    end
  end

  assign gf_io.state         = state_q;
  assign gf_io.frame_tick    = tick_q;
  assign gf_io.doodle_enable = en_q;
  assign gf_io.world_rst     = wrst_q;
  assign gf_io.scroll_step   = step_q;
  assign gf_io.scroll_total  = tot_q;
  assign gf_io.score         = score_q;
  assign gf_io.best_score    = best_q;
endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: reset, restart timing,
// scroll/score frames, death, best score, saturation and wrap.
module tb_game_flow_controller;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  game_flow_controller_if #(.SCORE_W(16)) gf ();

  game_flow_controller dut (
    .clk   (clk),
    .rst   (rst),
    .gf_io (gf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(gf.state), 0);
    check({tag, "_tick"},  32'(gf.frame_tick), 0);
    check({tag, "_en"},    32'(gf.doodle_enable), 0);
    check({tag, "_wrst"},  32'(gf.world_rst), 0);
    check({tag, "_step"},  32'(gf.scroll_step), 0);
    check({tag, "_tot"},   32'(gf.scroll_total), 0);
    check({tag, "_score"}, 32'(gf.score), 0);
    check({tag, "_best"},  32'(gf.best_score), 0);
  endtask

  // called at a negedge; one frame = low for one cycle, then high
  task automatic frame(input logic [9:0]  y,
                       input logic        f,
                       input logic [4:0]  es,
                       input logic [1:0]  est,
                       input logic [15:0] et,
                       input logic [15:0] esc);
    gf.doodle_y       = y;
    gf.doodle_falling = f;
    gf.switch_frame   = 1'b0;
    @(negedge clk);
    check("frm_tick",  32'(gf.frame_tick), 1);
    check("frm_step",  32'(gf.scroll_step), 32'(es));
    check("frm_state", 32'(gf.state), 32'(est));
    check("frm_total", 32'(gf.scroll_total), 32'(et));
    check("frm_score", 32'(gf.score), 32'(esc));
    gf.switch_frame = 1'b1;
    @(negedge clk);
    check("frm_tick_off", 32'(gf.frame_tick), 0);
    check("frm_step_off", 32'(gf.scroll_step), 0);
  endtask

  task automatic press_to_play(input logic [15:0] best);
    gf.button_left = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i <= 4) begin
        check("rs_state", 32'(gf.state), 1);
        check("rs_wrst",  32'(gf.world_rst), 1);
        check("rs_score", 32'(gf.score), 0);
        check("rs_total", 32'(gf.scroll_total), 0);
        check("rs_best",  32'(gf.best_score), 32'(best));
      end else begin
        check("rs_play", 32'(gf.state), 2);
        check("rs_en",   32'(gf.doodle_enable), 1);
      end
    end
    gf.button_left = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] acc;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    gf.switch_frame   = 1'b1;
    gf.button_left    = 1'b0;
    gf.button_right   = 1'b1;
    gf.doodle_y       = 10'd400;
    gf.doodle_falling = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tick",  32'(gf.frame_tick), 0);
    check("post_rst_state", 32'(gf.state), 0);
    @(negedge clk);
    check("held_btn_idle", 32'(gf.state), 0);
    gf.button_right = 1'b0;
    @(negedge clk);

    // right button held for 10 cycles: one restart, 4 cycles of world_rst
    gf.button_right = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i <= 4) begin
        check("rs1_state", 32'(gf.state), 1);
        check("rs1_wrst",  32'(gf.world_rst), 1);
        check("rs1_en",    32'(gf.doodle_enable), 0);
      end else begin
        check("rs1_state", 32'(gf.state), 2);
        check("rs1_wrst",  32'(gf.world_rst), 0);
        check("rs1_en",    32'(gf.doodle_enable), 1);
      end
    end
    gf.button_right = 1'b0;
    @(negedge clk);

    frame(10'd290, 1'b0, 5'd10, 2'd2, 16'd10, 16'd10);
    frame(10'd100, 1'b0, 5'd16, 2'd2, 16'd26, 16'd26);
    frame(10'd250, 1'b1, 5'd0,  2'd2, 16'd26, 16'd26);
    frame(10'd400, 1'b0, 5'd0,  2'd2, 16'd26, 16'd26);
    frame(10'd300, 1'b0, 5'd0,  2'd2, 16'd26, 16'd26);
    frame(10'd709, 1'b0, 5'd0,  2'd2, 16'd26, 16'd26);
    frame(10'd710, 1'b0, 5'd0,  2'd3, 16'd26, 16'd26);
    check("over_best", 32'(gf.best_score), 26);
    check("over_en",   32'(gf.doodle_enable), 0);

    press_to_play(16'd26);
    frame(10'd299, 1'b0, 5'd1, 2'd2, 16'd1, 16'd1);
    frame(10'd710, 1'b0, 5'd0, 2'd3, 16'd1, 16'd1);
    check("best_kept", 32'(gf.best_score), 26);

    press_to_play(16'd26);
    acc = 16'd0;
    for (int k = 0; k < 4095; k++) begin
      acc = acc + 16'd16;
      frame(10'd100, 1'b0, 5'd16, 2'd2, acc, acc);
    end
    frame(10'd292, 1'b0, 5'd8,  2'd2, 16'hFFF8, 16'hFFF8);
    frame(10'd200, 1'b0, 5'd16, 2'd2, 16'h0008, 16'hFFFF);
    frame(10'd280, 1'b0, 5'd16, 2'd2, 16'h0018, 16'hFFFF);
    frame(10'd720, 1'b1, 5'd0,  2'd3, 16'h0018, 16'hFFFF);
    check("sat_best", 32'(gf.best_score), 32'hFFFF);

    press_to_play(16'hFFFF);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("play_rst");
    rst = 1'b0;
    @(negedge clk);
    check("play_rst_tick",  32'(gf.frame_tick), 0);
    check("play_rst_state", 32'(gf.state), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
